// File: rtl/uart_tx_fifo_ctrl.sv
// Buffered 8N1 UART transmitter: byte-wide write port into a FIFO, drained LSB-first onto uart_tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo_ctrl #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [7:0]                    din,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          busy,
    output logic                          uart_tx
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int ADDR_W       = $clog2(FIFO_DEPTH);
    localparam int CNT_W        = ADDR_W + 1;
    localparam int BAUD_W       = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t state, state_next;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [ADDR_W:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count_next;
    logic [7:0]        head;
    logic              do_wr, pop;

    logic [BAUD_W-1:0] baud_cnt;
    logic              baud_done;
    logic [7:0]        shift_reg;
    logic [2:0]        bit_idx;
    logic              tx_bit;
`ifdef UART_TX_PARITY_EN
    logic              parity_bit;
`endif

    assign do_wr     = wr_en && !full;
    assign head      = mem[rd_ptr[ADDR_W-1:0]];
    assign baud_done = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[ADDR_W-1:0]] <= din;
        end
    end

    // Occupancy flags are registered from the next count, so a write while full is always
    // judged against the pre-edge full flag even if a pop happens on the same edge.
    always_comb begin
        count_next = count;
        case ({do_wr, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count_next;
            full     <= (count_next == CNT_W'(FIFO_DEPTH));
            empty    <= (count_next == '0);
            overflow <= wr_en && full;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        tx_bit     = 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                tx_bit = 1'b0;
                if (baud_done) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                tx_bit = shift_reg[0];
                if (baud_done && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_bit = parity_bit;
                if (baud_done) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The line is registered so it is glitch-free; it trails the FSM by one clock throughout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            uart_tx   <= 1'b1;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            uart_tx <= tx_bit;
            if (state == IDLE || state_next != state || baud_done) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
            if (pop) begin
                shift_reg <= head;
                bit_idx   <= '0;
`ifdef UART_TX_PARITY_EN
                parity_bit <= ^head;
`endif
            end else if (state == DATA && baud_done) begin
                shift_reg <= {1'b0, shift_reg[7:1]};
                bit_idx   <= bit_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed bench for uart_tx_fifo_ctrl at CLKS_PER_BIT=10, with a line decoder collecting frames.
// Honours UART_TX_PARITY_EN for frame length and parity checking.
module tb_uart_tx_fifo_ctrl;
    localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int PERIOD = NBITS * CPB + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] din = 8'h00;
    logic       full, empty, overflow, busy, uart_tx;
    logic [4:0] count;

    int cyc = 0;
    int errCount = 0;
    int checkCount = 0;

    logic [7:0] rxq[$];
    int         rxStart[$];
    logic [7:0] burst [5] = '{8'h00, 8'hFF, 8'h5A, 8'h01, 8'h88};

    uart_tx_fifo_ctrl #(
        .CLK_FREQ(100_000_000),
        .BAUD(10_000_000),
        .FIFO_DEPTH(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(wr_en),
        .din(din),
        .full(full),
        .empty(empty),
        .count(count),
        .overflow(overflow),
        .busy(busy),
        .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [7:0] d);
        wr_en = we;
        din   = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic monWait(input int n, inout logic ab);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            if (!rst_n) ab = 1'b1;
        end
    endtask

    // Line decoder: samples mid-bit, drops frames that saw a reset or a bad start/parity/stop.
    initial begin : monitor
        logic [7:0] b;
        logic       ok;
        logic       ab;
        int         st;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n && uart_tx === 1'b0) begin
                st = cyc;
                ab = 1'b0;
                monWait(5, ab);
                ok = (uart_tx === 1'b0);
                for (int k = 0; k < 8; k++) begin
                    monWait(10, ab);
                    b[k] = uart_tx;
                end
`ifdef UART_TX_PARITY_EN
                monWait(10, ab);
                ok = ok && (uart_tx === ^b);
`endif
                monWait(10, ab);
                ok = ok && (uart_tx === 1'b1);
                if (ok && !ab) begin
                    rxq.push_back(b);
                    rxStart.push_back(st);
                end
            end
        end
    end

    initial begin : watchdog
        #500us;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int wrCyc, nBusy, n, maxCount, ovfCnt;

        // Reset state
        repeat (3) tick();
        checkOutput("rst_uart_tx", uart_tx, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single byte A5: latency, busy length, decoded frame
        applyStimulus(1'b1, 8'hA5);
        wrCyc = cyc;
        checkOutput("a5_count_after_wr", count, 1);
        checkOutput("a5_empty_after_wr", empty, 0);
        checkOutput("a5_busy_after_wr", busy, 0);
        tick();
        checkOutput("a5_busy_after_pop", busy, 1);
        checkOutput("a5_empty_after_pop", empty, 1);
        checkOutput("a5_line_after_pop", uart_tx, 1);
        tick();
        checkOutput("a5_start_bit", uart_tx, 0);
        nBusy = 2;
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
            if (busy) nBusy++;
        end
        checkOutput("a5_busy_cycles", nBusy, NBITS * CPB);
        checkOutput("a5_rx_frames", rxq.size(), 1);
        if (rxq.size() >= 1) begin
            checkOutput("a5_rx_byte", rxq[0], 8'hA5);
            checkOutput("a5_start_latency", rxStart[0] - wrCyc, 2);
        end

        // Burst of five on consecutive cycles
        rxq.delete();
        rxStart.delete();
        maxCount = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, burst[i]);
            if (int'(count) > maxCount) maxCount = int'(count);
        end
        checkOutput("burst_count_peak", maxCount, 4);
        n = 0;
        while (rxq.size() < 5 && n < 800) begin
            tick();
            n++;
        end
        checkOutput("burst_rx_frames", rxq.size(), 5);
        if (rxq.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                checkOutput($sformatf("burst_byte%0d", i), rxq[i], burst[i]);
                if (i > 0) checkOutput($sformatf("burst_spacing%0d", i), rxStart[i] - rxStart[i-1], PERIOD);
            end
        end
        n = 0;
        while ((busy || !empty) && n < 300) begin
            tick();
            n++;
        end

        // Eighteen back-to-back writes: the last one arrives while full and is dropped
        rxq.delete();
        rxStart.delete();
        ovfCnt = 0;
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b1, 8'h10 + 8'(i));
            if (overflow) ovfCnt++;
            if (i == 15) checkOutput("ovf_not_full_at15", full, 0);
            if (i == 16) begin
                checkOutput("ovf_full_at16", full, 1);
                checkOutput("ovf_count_at16", count, 16);
            end
            if (i == 17) checkOutput("ovf_pulse_on_drop", overflow, 1);
        end
        checkOutput("ovf_pulse_total", ovfCnt, 1);
        tick();
        checkOutput("ovf_pulse_width", overflow, 0);
        checkOutput("ovf_count_held", count, 16);

        // Write coinciding with a pop at count=15
        n = 0;
        while (count != 5'd15 && n < 300) begin
            tick();
            n++;
        end
        checkOutput("simul_pre_count", count, 15);
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        applyStimulus(1'b1, 8'h77);
        checkOutput("simul_count", count, 15);
        checkOutput("simul_full", full, 0);
        checkOutput("simul_busy", busy, 1);
        n = 0;
        while (rxq.size() < 18 && n < 2500) begin
            tick();
            n++;
        end
        checkOutput("ovf_rx_frames", rxq.size(), 18);
        if (rxq.size() == 18) begin
            for (int i = 0; i < 17; i++) begin
                checkOutput($sformatf("ovf_byte%0d", i), rxq[i], 8'h10 + 8'(i));
            end
            checkOutput("simul_byte", rxq[17], 8'h77);
        end
        n = 0;
        while ((busy || !empty) && n < 300) begin
            tick();
            n++;
        end

        // Reset in the middle of the data bits of 41, with 99 still queued
        rxq.delete();
        rxStart.delete();
        applyStimulus(1'b1, 8'h41);
        applyStimulus(1'b1, 8'h99);
        checkOutput("rstmid_count_before", count, 1);
        repeat (40) tick();
        checkOutput("rstmid_busy_before", busy, 1);
        rst_n = 1'b0;
        tick();
        checkOutput("rstmid_uart_tx", uart_tx, 1);
        checkOutput("rstmid_busy", busy, 0);
        checkOutput("rstmid_count", count, 0);
        checkOutput("rstmid_empty", empty, 1);
        tick();
        rst_n = 1'b1;
        repeat (150) tick();
        checkOutput("rstmid_no_frames", rxq.size(), 0);
        checkOutput("rstmid_line_idle", uart_tx, 1);
        applyStimulus(1'b1, 8'h42);
        n = 0;
        while (rxq.size() < 1 && n < 300) begin
            tick();
            n++;
        end
        checkOutput("after_rst_frames", rxq.size(), 1);
        if (rxq.size() >= 1) checkOutput("after_rst_byte", rxq[0], 8'h42);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
